instruction_fetch: RTL and testbench

//  IF stage. Owns the program counter and drives the address of the combinational

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 71 +++++++
 rtl/instruction_fetch.sv | 78 +++++++
 tb/tb_instruction_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, fetch buffer entry type and
// PC helpers used by the fetch stage and its buffer.
package riscv_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int INSTR_WIDTH = 32;

   localparam logic [DATA_WIDTH-1:0]  PC_INCR   = DATA_WIDTH'(4);
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned, so a redirect target drops its two low bits.
   function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] pc);
      return pc & ~DATA_WIDTH'(3);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous in-order FIFO holding fetched {pc, instr} entries. The head entry is
// read straight out of the storage register so no input reaches o_head combinationally.
module fetch_buffer #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [31:0]
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  T                         i_data,
   output T                         o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]    CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]    CNT_MAX = (PTR_W + 1)'(DEPTH);

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_full    = (r_count == CNT_MAX);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];

   // A push while full is only legal when the head leaves in the same cycle.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage is reset (not left as raw RAM) so the head reads zero out of
         // reset; at this depth it is a handful of flops, so the reset costs nothing.
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, reads the combinational instruction memory and queues
// {pc, instr} pairs for decode; decode redirects flush the queue and restart fetch.
module instruction_fetch
   import riscv_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [DATA_WIDTH-1:0]  o_imem_addr,
   input  logic [INSTR_WIDTH-1:0] i_imem_instr,
   input  logic                   i_redirect_valid,
   input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
   output logic                   o_if_valid,
   output logic [DATA_WIDTH-1:0]  o_if_pc,
   output logic [DATA_WIDTH-1:0]  o_if_pc_plus4,
   output logic [INSTR_WIDTH-1:0] o_if_instr,
   input  logic                   i_id_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] r_pc;

   fetch_entry_t          w_push_entry;
   fetch_entry_t          w_head;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic                  w_pop;
   logic                  w_push;

   assign o_imem_addr  = r_pc;

   // Redirect wins over everything; otherwise fetch whenever a slot is or becomes free.
   assign w_pop        = o_if_valid & i_id_ready;
   assign w_push       = ~i_redirect_valid & (~w_full | w_pop);
   assign w_push_entry = '{pc: r_pc, instr: i_imem_instr};

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples the
      // pre-edge values regardless of block ordering.
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (i_redirect_valid) begin
         r_pc <= align_pc(i_redirect_pc);
      end else if (w_push) begin
         r_pc <= r_pc + PC_INCR;
      end
   end

   fetch_buffer #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_entry_t)
   ) u_fetch_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .i_data  (w_push_entry),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign o_if_valid    = ~w_empty;
   assign o_if_pc       = w_head.pc;
   assign o_if_instr    = w_head.instr;
   // Zero while empty so the reset view of the head is all zeroes.
   assign o_if_pc_plus4 = o_if_valid ? (w_head.pc + PC_INCR) : '0;

   a_count_bounded : assert property (@(posedge clk) disable iff (!rst_n)
      w_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run,
// all compared against a queue-based model of the fetch stage.
module tb_instruction_fetch;
   import riscv_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_instr;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;
   logic        o_if_valid;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_pc_plus4;
   logic [31:0] o_if_instr;
   logic        i_id_ready;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] p4;
      logic [31:0] addr;
   } obs_t;

   fetch_entry_t m_q[$];
   logic [31:0]  m_pc;
   obs_t         obs[$];
   obs_t         dlv[$];
   int           n_checks = 0;
   int           n_pass   = 0;

   instruction_fetch #(
      .RESET_PC   (RPC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_imem_addr      (o_imem_addr),
      .i_imem_instr     (i_imem_instr),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_if_valid       (o_if_valid),
      .o_if_pc          (o_if_pc),
      .o_if_pc_plus4    (o_if_pc_plus4),
      .o_if_instr       (o_if_instr),
      .i_id_ready       (i_id_ready)
   );

   always #5 clk = ~clk;

   // Memory image: word i holds i+1.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   always_comb i_imem_instr = rst_n ? mem_word(o_imem_addr) : NOP_INSTR;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc = RPC;
   endtask

   // One clock: drive inputs, sample/compare at the falling edge, then advance the model.
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
      obs_t o;
      logic pop;
      i_redirect_valid = rv;
      i_redirect_pc    = rpc;
      i_id_ready       = rdy;
      @(negedge clk);
      o = '{valid: o_if_valid, pc: o_if_pc, instr: o_if_instr, p4: o_if_pc_plus4, addr: o_imem_addr};
      obs.push_back(o);
      if (o_if_valid && rdy) dlv.push_back(o);
      check("imem_addr", o_imem_addr, m_pc);
      check("if_valid", 32'(o_if_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         check("if_pc", o_if_pc, m_q[0].pc);
         check("if_instr", o_if_instr, m_q[0].instr);
         check("if_pc_plus4", o_if_pc_plus4, m_q[0].pc + 32'd4);
      end
      pop = (m_q.size() > 0) && rdy;
      @(posedge clk);
      if (rv) begin
         m_q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else if (m_q.size() < DEPTH || pop) begin
         if (pop) void'(m_q.pop_front());
         m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
         m_pc = m_pc + 32'd4;
      end
      #1;
   endtask

   task automatic begin_seg();
      obs.delete();
      dlv.delete();
   endtask

   task automatic apply_reset();
      rst_n            = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_pc    = '0;
      i_id_ready       = 1'b1;
      #2;
      check("rst_valid", 32'(o_if_valid), 32'd0);
      check("rst_pc", o_if_pc, 32'd0);
      check("rst_pc_plus4", o_if_pc_plus4, 32'd0);
      check("rst_instr", o_if_instr, 32'd0);
      check("rst_imem_addr", o_imem_addr, RPC);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      // 1) Streaming from reset
      apply_reset();
      begin_seg();
      repeat (6) cycle(1'b0, '0, 1'b1);
      check("t1_valid_c0", 32'(obs[0].valid), 32'd0);
      check("t1_valid_c1", 32'(obs[1].valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         check("t1_pc", obs[i+1].pc, 32'(4 * i));
         check("t1_instr", obs[i+1].instr, 32'(i + 1));
      end

      // 2) Decode stalled for 5 cycles, then drains
      apply_reset();
      begin_seg();
      repeat (5) cycle(1'b0, '0, 1'b0);
      check("t2_addr_hold_c2", obs[2].addr, 32'h8);
      check("t2_addr_hold_c4", obs[4].addr, 32'h8);
      check("t2_pc_hold", obs[4].pc, 32'h0);
      repeat (4) cycle(1'b0, '0, 1'b1);
      check("t2_n_delivered", 32'(dlv.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_dlv_pc", dlv[i].pc, 32'(4 * i));
      end

      // 3) Redirect while full
      begin_seg();
      repeat (3) cycle(1'b0, '0, 1'b0);
      cycle(1'b1, 32'h0000_0103, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b1);
      check("t3_full_addr", obs[2].addr, obs[1].addr);
      check("t3_valid_n1", 32'(obs[4].valid), 32'd0);
      check("t3_addr_n1", obs[4].addr, 32'h100);
      check("t3_valid_n2", 32'(obs[5].valid), 32'd1);
      check("t3_pc_n2", obs[5].pc, 32'h100);
      check("t3_p4_n2", obs[5].p4, 32'h104);

      // 4) Back-to-back redirects
      cycle(1'b1, 32'h40, 1'b1);
      begin_seg();
      cycle(1'b1, 32'h80, 1'b1);
      repeat (4) cycle(1'b0, '0, 1'b1);
      check("t4_addr_first", obs[0].addr, 32'h40);
      check("t4_valid_gap", 32'(obs[1].valid), 32'd0);
      check("t4_first_pc", dlv[0].pc, 32'h80);
      foreach (dlv[i]) check("t4_no_0x40", 32'(dlv[i].pc == 32'h40), 32'd0);

      // 5) Redirect to the top word: PC wraps to zero
      cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
      begin_seg();
      repeat (4) cycle(1'b0, '0, 1'b1);
      check("t5_pc0", dlv[0].pc, 32'hFFFF_FFFC);
      check("t5_p4_0", dlv[0].p4, 32'h0);
      check("t5_instr0", dlv[0].instr, 32'h4000_0000);
      check("t5_pc1", dlv[1].pc, 32'h0);

      // 6) Asynchronous reset mid-stream
      repeat (3) cycle(1'b0, '0, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_valid_async", 32'(o_if_valid), 32'd0);
      check("t6_addr_async", o_imem_addr, RPC);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      begin_seg();
      repeat (4) cycle(1'b0, '0, 1'b1);
      check("t6_valid_c0", 32'(obs[0].valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("t6_dlv_pc", dlv[i].pc, 32'(4 * i));
      end

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic        rv;
         logic [31:0] rpc;
         logic        rdy;
         rv  = ($urandom_range(0, 15) == 0);
         rpc = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         cycle(rv, rpc, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
